// File: rtl/mul4_seq.sv
// Purpose: 4x4 unsigned shift-and-add multiplier reusing one four_adder per bit.
// Latency: 4 cycles from the accepting edge to done; 5-cycle throughput.
// Backpressure: none; start is only sampled in IDLE or DONE, ignored while busy.
module mul4_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] m_q, m_d;
    logic [3:0] hi_q, hi_d;
    logic [3:0] lo_q, lo_d;
    logic [1:0] cnt_q, cnt_d;

    logic [3:0] af;
    logic [3:0] bf;
    logic       cin;
    logic [3:0] s;
    logic       c;

    assign af  = hi_q;
    assign bf  = lo_q[0] ? m_q : 4'b0;
    assign cin = 1'b0;

    four_adder u_add (
        .af   (af),
        .bf   (bf),
        .cin  (cin),
        .sum  (s),
        .cout (c)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    m_d     = a;
                    lo_d    = b;
                    hi_d    = 4'b0;
                    cnt_d   = 2'd0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                // Shift the adder result right by one across the {hi, lo} pair.
                hi_d  = {c, s[3:1]};
                lo_d  = {s[0], lo_q[3:1]};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= 4'b0;
            hi_q    <= 4'b0;
            lo_q    <= 4'b0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy    = (state_q == CALC);
    assign done    = (state_q == DONE);
    assign product = {hi_q, lo_q};

endmodule

// Purpose: 4-bit ripple-carry adder, the multiplier's only arithmetic element.
// Latency: purely combinational.
// Backpressure: none.
module four_adder (
    input  logic [3:0] af,
    input  logic [3:0] bf,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    always_comb begin
        carry    = 5'b0;
        sum      = 4'b0;
        carry[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]     = af[i] ^ bf[i] ^ carry[i];
            carry[i+1] = (af[i] & bf[i]) | (carry[i] & (af[i] ^ bf[i]));
        end
        cout = carry[4];
    end

endmodule

// File: tb/tb_mul4_seq.sv
// Directed and swept checks of mul4_seq: handshake timing, ignored starts,
// back-to-back restart, mid-operation reset and product correctness.
module tb_mul4_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    mul4_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    // One full multiply: accept, check busy window, done latency, product and hold.
    task automatic do_mul(input logic [3:0] va, input logic [3:0] vb, input logic [7:0] exp);
        int k;
        a     = va;
        b     = vb;
        start = 1'b1;
        edge_step();
        start = 1'b0;
        a     = $urandom_range(0, 15);
        b     = $urandom_range(0, 15);
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
        chk("done_after_accept", {31'b0, done}, 32'd0);
        k = 0;
        while (!done && k < 8) begin
            edge_step();
            k++;
            if (busy && done) chk("busy_done_overlap", 32'd1, 32'd0);
        end
        chk("done_latency", k, 4);
        chk("product", {24'b0, product}, {24'b0, exp});
        edge_step();
        chk("done_pulse_end", {31'b0, done}, 32'd0);
        chk("idle_not_busy", {31'b0, busy}, 32'd0);
        chk("product_held", {24'b0, product}, {24'b0, exp});
    endtask

    initial begin
        logic       seen_done;
        logic [3:0] ra, rb;

        vecs[0] = '{4'h0, 4'h0, 8'h00};
        vecs[1] = '{4'hF, 4'hF, 8'hE1};
        vecs[2] = '{4'h7, 4'h9, 8'h3F};
        vecs[3] = '{4'h1, 4'hF, 8'h0F};
        vecs[4] = '{4'hF, 4'h1, 8'h0F};
        vecs[5] = '{4'h8, 4'h8, 8'h40};
        vecs[6] = '{4'hA, 4'h5, 8'h32};
        vecs[7] = '{4'hC, 4'h3, 8'h24};

        rst_n = 1'b0;
        start = 1'b0;
        a     = 4'h0;
        b     = 4'h0;
        edge_step();
        edge_step();
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_product", {24'b0, product}, 32'd0);

        // Reset wins over a coincident start.
        start = 1'b1;
        edge_step();
        chk("rst_start_busy", {31'b0, busy}, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        edge_step();

        for (int i = 0; i < 8; i++) begin
            do_mul(vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Start during CALC is ignored, then start held into DONE restarts.
        a = 4'h3; b = 4'h5; start = 1'b1;
        edge_step();
        chk("seq_busy", {31'b0, busy}, 32'd1);
        a = 4'hF; b = 4'hF;
        edge_step();
        edge_step();
        edge_step();
        chk("seq_still_busy", {31'b0, busy}, 32'd1);
        a = 4'h2; b = 4'h6;
        edge_step();
        chk("seq_done", {31'b0, done}, 32'd1);
        chk("seq_busy_low", {31'b0, busy}, 32'd0);
        chk("seq_product_0f", {24'b0, product}, 32'h0F);
        edge_step();
        start = 1'b0;
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        chk("b2b_done_low", {31'b0, done}, 32'd0);
        edge_step();
        edge_step();
        edge_step();
        edge_step();
        chk("b2b_done", {31'b0, done}, 32'd1);
        chk("b2b_product_0c", {24'b0, product}, 32'h0C);
        edge_step();

        // Reset in the second CALC cycle discards the operation.
        a = 4'h9; b = 4'h9; start = 1'b1;
        edge_step();
        start = 1'b0;
        edge_step();
        rst_n = 1'b0;
        edge_step();
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_product", {24'b0, product}, 32'd0);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            edge_step();
            if (done) seen_done = 1'b1;
        end
        chk("midrst_no_done", {31'b0, seen_done}, 32'd0);

        for (int i = 0; i < 256; i++) begin
            ra = i[7:4];
            rb = i[3:0];
            do_mul(ra, rb, 8'(ra) * 8'(rb));
        end
        for (int i = 0; i < 512; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            do_mul(ra, rb, 8'(ra) * 8'(rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
